// File: rtl/wb_uart_tx_core.sv
// Wishbone-slave UART transmitter: register file, TX FIFO, baud generator and 8N1 serializer.
// Bus accesses are single-cycle acked; the serializer drains the FIFO onto tx.
module wb_uart_tx_core #(
   parameter int unsigned FIFO_W    = 4,
   parameter logic [15:0] DVSR_INIT = 16'd53,
   parameter int unsigned SB_TICK   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  ADDR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   output logic        ACK_O,
   output logic        tx
);
   localparam int unsigned DEPTH = 1 << FIFO_W;
   localparam int unsigned CNT_W = FIFO_W + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [7:0]        mem_q [DEPTH];
   logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [15:0]       dvsr_q, dvsr_d, bcnt_q, bcnt_d;
   logic              ack_q, ack_d, tx_q, tx_d;
   logic [31:0]       dat_q, dat_d;
   logic [1:0]        state_q, state_d;
   logic [3:0]        s_q, s_d;
   logic [2:0]        n_q, n_d;
   logic [7:0]        b_q, b_d;

   logic req, wr_tx, push, pop, full, empty, busy, tick, dvsr_wr, ovf_clr;
   logic unused_dat;

   // Bus decode, registers and FIFO bookkeeping
   always_comb begin
      req        = CYC_I & STB_I & ~ack_q;
      unused_dat = ^DAT_I[31:16];
      full       = (cnt_q == CNT_W'(DEPTH));
      empty      = (cnt_q == '0);
      busy       = (state_q != ST_IDLE);
      tick       = (bcnt_q == dvsr_q);
      wr_tx      = req & WE_I & (ADDR_I == 5'd1);
      push       = wr_tx & ~full;
      dvsr_wr    = req & WE_I & (ADDR_I == 5'd0);
      ovf_clr    = req & WE_I & (ADDR_I == 5'd3) & DAT_I[0];
      pop        = (state_q == ST_IDLE) & ~empty;

      ack_d    = req;
      dat_d    = '0;
      if (req && !WE_I) begin
         case (ADDR_I)
            5'd0:    dat_d = {16'h0000, dvsr_q};
            5'd2:    dat_d = 32'({cnt_q, 4'b0000, ovf_q, busy, empty, full});
            default: dat_d = '0;
         endcase
      end

      dvsr_d   = dvsr_wr ? DAT_I[15:0] : dvsr_q;
      bcnt_d   = (dvsr_wr || tick) ? 16'd0 : bcnt_q + 16'd1;
      wr_ptr_d = push ? wr_ptr_q + FIFO_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + FIFO_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      // A dropped push wins over a same-edge clear
      ovf_d    = wr_tx & full ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   // Serializer next-state; tx follows the state being entered
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               b_d     = mem_q[rd_ptr_q];
               s_d     = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_q == 4'd15) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = ST_DATA;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_q == 4'd15) begin
                  s_d = '0;
                  b_d = {1'b0, b_q[7:1]};
                  if (n_q == 3'd7) state_d = ST_STOP;
                  else             n_d     = n_q + 3'd1;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: begin
            if (tick) begin
               if (s_q == 4'(SB_TICK - 1)) state_d = ST_IDLE;
               else                        s_d     = s_q + 4'd1;
            end
         end
      endcase
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = b_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         dvsr_q   <= DVSR_INIT;
         bcnt_q   <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
         tx_q     <= 1'b1;
         state_q  <= ST_IDLE;
         s_q      <= '0;
         n_q      <= '0;
         b_q      <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         dvsr_q   <= dvsr_d;
         bcnt_q   <= bcnt_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
         tx_q     <= tx_d;
         state_q  <= state_d;
         s_q      <= s_d;
         n_q      <= n_d;
         b_q      <= b_d;
      end
   end

   // FIFO storage; contents are don't-care outside the valid window
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= DAT_I[7:0];
   end

   assign ACK_O = ack_q;
   assign DAT_O = dat_q;
   assign tx    = tx_q;
endmodule
